// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory line port between the I-cache and D-cache; define MEM_ARB_RR_EN for round-robin on simultaneous requests
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_read_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic              data_read_i,
    input  logic              data_write_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [LINE_W-1:0] data_wdata_i,
    output logic              instr_mem_resp_o,
    output logic [LINE_W-1:0] instr_rdata_o,
    output logic              data_mem_resp_o,
    output logic [LINE_W-1:0] data_rdata_o,
    output logic              pmem_read_o,
    output logic              pmem_write_o,
    output logic [ADDR_W-1:0] pmem_addr_o,
    output logic [LINE_W-1:0] pmem_wdata_o,
    input  logic [LINE_W-1:0] pmem_rdata_i,
    input  logic              pmem_resp_i
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_n;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              data_req, grant_d, grant_i;
    assign data_req = data_read_i | data_write_i;
`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign grant_d = data_req & ~(instr_read_i & last_d);
    // remember the last winner so the other port takes the next tie; reset lets data win first
    always_ff @(posedge clk or posedge rst)
        if (rst) last_d <= 1'b0;
        else if (state == IDLE && (grant_d | grant_i)) last_d <= grant_d;
`else
    assign grant_d = data_req;
`endif
    assign grant_i = instr_read_i & ~grant_d;
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // capture the granted request so later input changes cannot disturb the transaction
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            op_write <= 1'b0;
        end else if (state == IDLE && grant_d) begin
            addr_q   <= data_addr_i;
            wdata_q  <= data_wdata_i;
            op_write <= data_write_i;
        end else if (state == IDLE && grant_i) begin
            addr_q   <= instr_addr_i;
            wdata_q  <= '0;
            op_write <= 1'b0;
        end
    // grant from IDLE, then stay until memory completes; illegal encodings fall back to IDLE
    always_comb begin
        state_n = IDLE;
        if (state == IDLE) state_n = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
        else if (state == SERVE_I || state == SERVE_D) state_n = pmem_resp_i ? IDLE : state;
    end
    assign pmem_read_o      = state == SERVE_I || (state == SERVE_D && !op_write);
    assign pmem_write_o     = state == SERVE_D && op_write;
    assign pmem_addr_o      = addr_q;
    assign pmem_wdata_o     = wdata_q;
    assign instr_mem_resp_o = state == SERVE_I && pmem_resp_i;
    assign data_mem_resp_o  = state == SERVE_D && pmem_resp_i;
    assign instr_rdata_o    = instr_mem_resp_o ? pmem_rdata_i : '0;
    assign data_rdata_o     = data_mem_resp_o ? pmem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latching, reset and response behaviour of mem_arbiter
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_read_i = 1'b0;
    logic [ADDR_W-1:0] instr_addr_i = '0;
    logic              data_read_i = 1'b0;
    logic              data_write_i = 1'b0;
    logic [ADDR_W-1:0] data_addr_i = '0;
    logic [LINE_W-1:0] data_wdata_i = '0;
    logic              instr_mem_resp_o, data_mem_resp_o, pmem_read_o, pmem_write_o;
    logic [LINE_W-1:0] instr_rdata_o, data_rdata_o, pmem_wdata_o;
    logic [ADDR_W-1:0] pmem_addr_o;
    logic [LINE_W-1:0] pmem_rdata_i = '0;
    logic              pmem_resp_i = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int s_rd, s_wr, s_ir, s_dr, s_gap;
    logic s_chg, s_to;
    logic [ADDR_W-1:0] s_addr;
    logic [LINE_W-1:0] s_line;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .instr_read_i(instr_read_i), .instr_addr_i(instr_addr_i),
        .data_read_i(data_read_i), .data_write_i(data_write_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .instr_mem_resp_o(instr_mem_resp_o), .instr_rdata_o(instr_rdata_o),
        .data_mem_resp_o(data_mem_resp_o), .data_rdata_o(data_rdata_o),
        .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
        .pmem_addr_o(pmem_addr_o), .pmem_wdata_o(pmem_wdata_o),
        .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pmem_resp_i = 1'b0;
        end
    endtask

    // memory model: answers after lat strobe cycles and records what the arbiter did
    task automatic serve(input int lat, input logic [LINE_W-1:0] line, input bit do_mid, input logic [ADDR_W-1:0] mid_addr);
        int strobes = 0;
        s_rd = 0; s_wr = 0; s_ir = 0; s_dr = 0; s_gap = 0;
        s_chg = 1'b0; s_to = 1'b1; s_addr = '0; s_line = '0;
        for (int c = 0; c < 30 && s_to; c++) begin
            @(negedge clk);
            pmem_resp_i = 1'b0;
            pmem_rdata_i = '0;
            #1;
            if (pmem_read_o || pmem_write_o) begin
                if (strobes == 0) s_addr = pmem_addr_o;
                else if (pmem_addr_o !== s_addr) s_chg = 1'b1;
                strobes++;
                s_rd += int'(pmem_read_o);
                s_wr += int'(pmem_write_o);
                if (do_mid && strobes == 1) begin
                    data_addr_i = mid_addr;
                    data_wdata_i = '1;
                end
                if (strobes == lat) begin
                    pmem_resp_i = 1'b1;
                    pmem_rdata_i = line;
                    #1;
                    s_to = 1'b0;
                    s_line = instr_mem_resp_o ? instr_rdata_o : data_rdata_o;
                end
            end else if (strobes == 0) s_gap++;
            s_ir += int'(instr_mem_resp_o);
            s_dr += int'(data_mem_resp_o);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({pmem_read_o, pmem_write_o, instr_mem_resp_o, data_mem_resp_o} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {pmem_read_o, pmem_write_o, instr_mem_resp_o, data_mem_resp_o});
        end
        n_tests++;
        if (pmem_addr_o !== '0 || pmem_wdata_o !== '0) begin
            n_fail++; $display("FAIL reset_regs: addr %h wdata %h want 0", pmem_addr_o, pmem_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_instr_read();
        idle(1);
        instr_read_i = 1'b1;
        instr_addr_i = 32'h40;
        serve(3, {32{8'hA5}}, 1'b0, '0);
        instr_read_i = 1'b0;
        n_tests++;
        if (s_to !== 1'b0 || s_gap != 0 || s_rd != 3 || s_wr != 0) begin
            n_fail++; $display("FAIL instr_strobes: to %b gap %0d rd %0d wr %0d want 0 0 3 0", s_to, s_gap, s_rd, s_wr);
        end
        n_tests++;
        if (s_ir != 1 || s_dr != 0) begin
            n_fail++; $display("FAIL instr_resp: iresp %0d dresp %0d want 1 0", s_ir, s_dr);
        end
        n_tests++;
        if (s_line !== {32{8'hA5}} || s_addr !== 32'h40) begin
            n_fail++; $display("FAIL instr_data: line %h addr %h want a5.. 40", s_line, s_addr);
        end
    endtask

    task automatic test_priority();
        idle(2);
        instr_read_i = 1'b1;
        instr_addr_i = 32'h100;
        data_read_i = 1'b1;
        data_addr_i = 32'h200;
        serve(2, {8{32'hD00D_0001}}, 1'b0, '0);
        data_read_i = 1'b0;
        n_tests++;
        if (s_addr !== 32'h200 || s_dr != 1 || s_ir != 0 || s_rd != 2) begin
            n_fail++; $display("FAIL prio_first: addr %h dresp %0d iresp %0d rd %0d want 200 1 0 2", s_addr, s_dr, s_ir, s_rd);
        end
        n_tests++;
        if (s_line !== {8{32'hD00D_0001}}) begin
            n_fail++; $display("FAIL prio_rdata: got %h", s_line);
        end
        serve(2, {8{32'h1111_2222}}, 1'b0, '0);
        instr_read_i = 1'b0;
        n_tests++;
        if (s_to !== 1'b0 || s_addr !== 32'h100 || s_gap != 1 || s_ir != 1 || s_dr != 0) begin
            n_fail++; $display("FAIL prio_second: to %b addr %h gap %0d iresp %0d dresp %0d want 0 100 1 1 0", s_to, s_addr, s_gap, s_ir, s_dr);
        end
    endtask

    task automatic test_tie_after_data();
        idle(2);
        data_read_i = 1'b1;
        data_addr_i = 32'h240;
        serve(1, '0, 1'b0, '0);
        data_read_i = 1'b0;
        idle(2);
        instr_read_i = 1'b1;
        instr_addr_i = 32'h100;
        data_read_i = 1'b1;
        data_addr_i = 32'h200;
        serve(2, '0, 1'b0, '0);
        instr_read_i = 1'b0;
        data_read_i = 1'b0;
        n_tests++;
        if (s_addr !== (RR ? 32'h100 : 32'h200)) begin
            n_fail++; $display("FAIL tie_winner: got %h want %h", s_addr, RR ? 32'h100 : 32'h200);
        end
    endtask

    task automatic test_write_latch();
        idle(2);
        data_write_i = 1'b1;
        data_addr_i = 32'h300;
        data_wdata_i = {8{32'h1234_5678}};
        serve(3, '0, 1'b1, 32'h400);
        n_tests++;
        if (s_addr !== 32'h300 || s_chg !== 1'b0) begin
            n_fail++; $display("FAIL wr_addr_hold: addr %h changed %b want 300 0", s_addr, s_chg);
        end
        n_tests++;
        if (pmem_wdata_o !== {8{32'h1234_5678}}) begin
            n_fail++; $display("FAIL wr_wdata_hold: got %h", pmem_wdata_o);
        end
        data_write_i = 1'b0;
        n_tests++;
        if (s_wr != 3 || s_rd != 0 || s_dr != 1 || s_ir != 0) begin
            n_fail++; $display("FAIL wr_strobes: wr %0d rd %0d dresp %0d iresp %0d want 3 0 1 0", s_wr, s_rd, s_dr, s_ir);
        end
    endtask

    task automatic test_rd_wr_both();
        idle(2);
        data_read_i = 1'b1;
        data_write_i = 1'b1;
        data_addr_i = 32'h80;
        data_wdata_i = {8{32'hCAFE_F00D}};
        serve(2, '0, 1'b0, '0);
        data_read_i = 1'b0;
        data_write_i = 1'b0;
        n_tests++;
        if (s_wr != 2 || s_rd != 0 || s_dr != 1 || s_addr !== 32'h80) begin
            n_fail++; $display("FAIL rdwr_both: wr %0d rd %0d dresp %0d addr %h want 2 0 1 80", s_wr, s_rd, s_dr, s_addr);
        end
        idle(3);
        n_tests++;
        if (pmem_read_o !== 1'b0 || pmem_write_o !== 1'b0) begin
            n_fail++; $display("FAIL rdwr_idle: rd %b wr %b want 0 0", pmem_read_o, pmem_write_o);
        end
    endtask

    task automatic test_reset_mid();
        idle(2);
        data_read_i = 1'b1;
        data_addr_i = 32'h500;
        @(negedge clk);
        #1;
        n_tests++;
        if (pmem_read_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_start: rd %b want 1", pmem_read_o);
        end
        rst = 1'b1;
        pmem_resp_i = 1'b1;
        #1;
        n_tests++;
        if ({pmem_read_o, pmem_write_o, instr_mem_resp_o, data_mem_resp_o} !== 4'b0 || pmem_addr_o !== '0) begin
            n_fail++; $display("FAIL rstmid_async: ctrl %b addr %h want 0000 0", {pmem_read_o, pmem_write_o, instr_mem_resp_o, data_mem_resp_o}, pmem_addr_o);
        end
        data_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pmem_resp_i = 1'b0;
        instr_read_i = 1'b1;
        instr_addr_i = 32'h600;
        serve(2, {32{8'h3C}}, 1'b0, '0);
        instr_read_i = 1'b0;
        n_tests++;
        if (s_to !== 1'b0 || s_addr !== 32'h600 || s_ir != 1 || s_dr != 0 || s_line !== {32{8'h3C}}) begin
            n_fail++; $display("FAIL rstmid_after: to %b addr %h iresp %0d dresp %0d line %h", s_to, s_addr, s_ir, s_dr, s_line);
        end
    endtask

    task automatic test_spurious();
        int hits = 0;
        idle(2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pmem_resp_i = 1'b1;
            pmem_rdata_i = '1;
            #1;
            hits += int'(instr_mem_resp_o) + int'(data_mem_resp_o) + int'(pmem_read_o) + int'(pmem_write_o);
        end
        @(negedge clk);
        pmem_resp_i = 1'b0;
        n_tests++;
        if (hits != 0) begin
            n_fail++; $display("FAIL spurious_resp: got %0d active outputs want 0", hits);
        end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_priority();
        test_tie_after_data();
        test_write_latch();
        test_rd_wr_both();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte address width on all ports.
REQ-002 Parameter LINE_W, default 256, cacheline data width on all ports.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 instr_read_i  input  1  I-cache line-read request, held until instr_mem_resp_o.
REQ-006 instr_addr_i  input  ADDR_W  I-cache line address.
REQ-007 data_read_i  input  1  D-cache line-read request, held until data_mem_resp_o.
REQ-008 data_write_i  input  1  D-cache line-write request, held until data_mem_resp_o.
REQ-009 data_addr_i  input  ADDR_W  D-cache line address.
REQ-010 data_wdata_i  input  LINE_W  D-cache write line.
REQ-011 instr_mem_resp_o  output  1  one-cycle completion pulse to I-cache and pipeline stall control.
REQ-012 instr_rdata_o  output  LINE_W  I-cache read line, valid with instr_mem_resp_o.
REQ-013 data_mem_resp_o  output  1  one-cycle completion pulse to D-cache and pipeline stall control.
REQ-014 data_rdata_o  output  LINE_W  D-cache read line, valid with data_mem_resp_o.
REQ-015 pmem_read_o / pmem_write_o  output  1 each  physical-memory request strobes, never both high.
REQ-016 pmem_addr_o  output  ADDR_W  latched address of the granted request.
REQ-017 pmem_wdata_o  output  LINE_W  latched write line of the granted request.
REQ-018 pmem_rdata_i  input  LINE_W  physical-memory read line.
REQ-019 pmem_resp_i  input  1  physical-memory completion, one cycle.

Function
REQ-020 FSM states IDLE, SERVE_I, SERVE_D; exactly one state active.
REQ-021 IDLE: data request pending -> SERVE_D; else instr_read_i -> SERVE_I; else stay.
REQ-022 Both ports requesting in IDLE: data port granted (subject to REQ-034).
REQ-023 On grant, pmem_addr_o, pmem_wdata_o and op type (read/write) latched; held constant for the whole transaction.
REQ-024 data_read_i and data_write_i both high: write granted, read ignored.
REQ-025 pmem_read_o/pmem_write_o high every cycle in SERVE_x until and including the pmem_resp_i cycle; low in IDLE.
REQ-026 First pmem strobe cycle = cycle after the grant decision in IDLE.
REQ-027 pmem_resp_i in SERVE_D: data_mem_resp_o = 1 same cycle (combinational); data_rdata_o = pmem_rdata_i; next state IDLE.
REQ-028 pmem_resp_i in SERVE_I: instr_mem_resp_o = 1 same cycle; instr_rdata_o = pmem_rdata_i; next state IDLE.
REQ-029 Responses never asserted outside SERVE_x or for the non-granted port; never both in one cycle.
REQ-030 pmem_resp_i in IDLE ignored.
REQ-031 Requests deasserted mid-transaction are ignored; transaction runs to pmem_resp_i.
REQ-032 At least one IDLE cycle between consecutive transactions.

Reset
REQ-033 rst high: state IDLE immediately; all outputs 0 (resp, strobes, pmem_addr_o, pmem_wdata_o); any in-flight transaction abandoned, no response issued.

Configuration
REQ-034 Macro MEM_ARB_RR_EN defined: one-bit last-grant register; on simultaneous requests in IDLE, port not granted last wins; reset value favours data. Undefined: strict data priority per REQ-022, register absent.

Verification
REQ-035 Instr read only, addr 0x0000_0040, pmem_resp_i after 3 strobe cycles, rdata 0xA5..A5 -> pmem_read_o 3 cycles, instr_mem_resp_o one pulse with 0xA5..A5, data_mem_resp_o 0.
REQ-036 Instr read 0x100 and data read 0x200 together -> 0x200 served first, 0x100 starts after one IDLE cycle; with MEM_ARB_RR_EN, second simultaneous pair -> 0x100 first.
REQ-037 Data write 0x300, wdata 0x1234..: data_addr_i changed to 0x400 mid-transaction -> pmem_addr_o stays 0x300, pmem_write_o until resp, pmem_read_o 0.
REQ-038 data_read_i and data_write_i both high, addr 0x80 -> pmem_write_o only, one data_mem_resp_o.
REQ-039 rst asserted during SERVE_D before pmem_resp_i -> strobes low same cycle, no resp pulse, state IDLE; fresh instr request after reset served normally.
REQ-040 Spurious pmem_resp_i in IDLE -> no response outputs asserted.
